simple_system_onchip_ram_arbiter: RTL and testbench
===================================================

Name: simple_system_onchip_ram_arbiter

Overview:
- Shares one single-port 64-bit on-chip RAM (8192 words, byte enables, 1-cycle synchronous read) between two Avalon-MM-style requesters, m0 and m1.
- Typical pairing: m0 = processor data master, m1 = DMA/sensor logger.
- Round-robin arbitration with burst locking.
- Generates incrementing burst addresses.
- Returns read data with a fixed 1-cycle latency and a per-requester valid strobe.

Parameters:
- ADDR_W, 13, RAM word-address width.
- DATA_W, 64, data width.
- BE_W, 8, byte-enable width (DATA_W/8).
- BURST_W, 4, burstcount width; maximum burst is 2^BURST_W-1 beats.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mX_address  in  ADDR_W  word address (X = 0,1, same set for each requester)
- mX_byteenable  in  BE_W  write byte enables
- mX_read  in  1  read request
- mX_write  in  1  write request/beat
- mX_writedata  in  DATA_W  write data
- mX_burstcount  in  BURST_W  beats; 0 treated as 1
- mX_waitrequest  out  1  command/beat not accepted this cycle
- mX_readdata  out  DATA_W  read data
- mX_readdatavalid  out  1  mX_readdata valid this cycle
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  BE_W  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_readdata  in  DATA_W  from RAM (unregistered q)

Behaviour:
- Reset (while reset=1 and the cycle after):
  - state=IDLE; last_grant=1, so m0 wins the first tie.
  - All mX_waitrequest=1; mX_readdatavalid=0.
  - ram_chipselect=0, ram_write=0; beat counter and read pipeline cleared.
- Reset mid-burst: the burst is abandoned and any in-flight readdatavalid is dropped. RAM contents written before reset are kept.
- States: IDLE, RD_BURST, WR_BURST.
- IDLE:
  - A requester is "requesting" if read|write is set.
  - If exactly one requests, it wins. If both request, the one not equal to last_grant wins.
  - The grant is combinational in the same cycle: winner waitrequest=0, loser waitrequest=1.
  - The RAM is driven from the winner's address, byteenable and writedata; ram_chipselect=1.
  - last_grant updates at the clock edge.
- Read grant, N beats:
  - Beat 1 is issued at address A in the grant cycle.
  - If N>1: go to RD_BURST, addr_q=A+1, remaining=N-1.
- RD_BURST:
  - One read per cycle at addr_q with ram_byteenable=all ones; addr_q increments.
  - Both waitrequests=1; requester inputs are ignored.
  - Return to IDLE after the last beat. No bubble: IDLE arbitrates in the next cycle.
- Write grant, N beats:
  - Beat 1 is written in the grant cycle (ram_write=1).
  - If N>1: go to WR_BURST with addr_q and remaining as above.
- WR_BURST:
  - Owner waitrequest=0; other requester waitrequest=1.
  - A beat is written only in cycles with owner write=1, using owner byteenable and writedata at addr_q. addr_q and remaining then advance.
  - Owner write=0 writes nothing and the grant is held indefinitely (no timeout).
  - Return to IDLE after the last beat.
- Read return:
  - Registered issue flag and owner ID.
  - A read issued in cycle t gives mOwner_readdatavalid=1 in cycle t+1.
  - mX_readdata=ram_readdata for both ports (broadcast); only the valid strobe is per-port.
- Address arithmetic: modulo 2^ADDR_W, so 8191+1 -> 0 inside a burst.
- read and write both set on one requester: treated as a write; the read is ignored.
- Idle cycles: ram_chipselect=0 and ram_write=0. ram_byteenable=all ones whenever ram_write=0.

Optional Feature:
- Macro: RAM_ARB_STATS_EN.
- When defined, adds outputs stat_beats0, stat_beats1 and stat_conflict (32 bits each, saturating, cleared by reset):
  - stat_beatsX counts RAM beats issued for mX.
  - stat_conflict counts cycles where a requesting port had waitrequest=1.
- When undefined, these ports and their counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, m0 write addr 0x010 data 0x0123456789ABCDEF be 0xFF, then m0 read 0x010 -> readdatavalid in the cycle after the read grant, data 0x0123456789ABCDEF; m1_readdatavalid stays 0.
- m0 and m1 read simultaneously from reset -> m0 granted first, m1 next cycle. Repeat the simultaneous request -> m1 granted first (round-robin alternation).
- m1 read burst 4 at 0x1FFE -> RAM addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001 on consecutive cycles; 4 consecutive m1_readdatavalid; m0 held at waitrequest=1 throughout.
- m0 write burst 3 at 0x100 with write deasserted for 2 cycles after beat 1 -> exactly 3 RAM writes to 0x100..0x102; m1 blocked until the last beat.
- m0 write be=0x0F over a word of 0xFFFFFFFFFFFFFFFF with data 0 -> readback 0xFFFFFFFF00000000.
- Assert reset during beat 2 of a read burst 8 -> no further readdatavalid, state IDLE, waitrequest=1; after release, new requests are granted normally.

Source files
------------

// File: rtl/simple_system_onchip_ram_arbiter_if.sv
// Requester bus for simple_system_onchip_ram_arbiter (Avalon-MM style, burst capable).
//   address       word address
//   byteenable    write byte enables
//   read / write  command strobes (write wins when both are set)
//   writedata     write data
//   burstcount    beats in the burst, 0 is treated as 1
//   waitrequest   command/beat not accepted this cycle
//   readdata      read data (broadcast from the RAM)
//   readdatavalid readdata belongs to this requester this cycle
// master: requester side, slave: arbiter side.
interface simple_system_onchip_ram_arbiter_if #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BE_W    = 8,
  parameter int unsigned BURST_W = 4
);
  logic [ADDR_W-1:0]  address;
  logic [BE_W-1:0]    byteenable;
  logic               read;
  logic               write;
  logic [DATA_W-1:0]  writedata;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata, burstcount,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata, burstcount,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/simple_system_onchip_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// A granted burst locks the RAM until its last beat; burst addresses increment
// modulo 2^ADDR_W. Read data returns one cycle after issue with a per-port valid.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   m0, m1              requester buses (slave modport)
//   o_ram_*             RAM command/write side
//   i_ram_readdata      RAM q, valid the cycle after a read
//   o_stat_*            beat/conflict counters, only with RAM_ARB_STATS_EN defined
module simple_system_onchip_ram_arbiter #(
  parameter int unsigned ADDR_W  = 13,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned BE_W    = 8,
  parameter int unsigned BURST_W = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  simple_system_onchip_ram_arbiter_if.slave m0,
  simple_system_onchip_ram_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   o_ram_address,
  output logic [BE_W-1:0]     o_ram_byteenable,
  output logic                o_ram_chipselect,
  output logic                o_ram_write,
  output logic [DATA_W-1:0]   o_ram_writedata,
`ifdef RAM_ARB_STATS_EN
  output logic [31:0]         o_stat_beats0,
  output logic [31:0]         o_stat_beats1,
  output logic [31:0]         o_stat_conflict,
`endif
  input  logic [DATA_W-1:0]   i_ram_readdata
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_BURST = 2'd1;
  localparam logic [1:0] ST_WR_BURST = 2'd2;

  logic [1:0]         r_state;
  logic               r_last_grant;
  logic               r_owner;
  logic               r_rst_dly;
  logic [ADDR_W-1:0]  r_addr;
  logic [BURST_W-1:0] r_rem;
  logic               r_rd_vld;
  logic               r_rd_owner;

  logic [1:0]         w_state_nxt;
  logic               w_blk;
  logic               w_req0;
  logic               w_req1;
  logic               w_gnt_any;
  logic               w_gnt_id;
  logic [ADDR_W-1:0]  w_win_addr;
  logic [BE_W-1:0]    w_win_be;
  logic [DATA_W-1:0]  w_win_wdata;
  logic               w_win_write;
  logic [BURST_W-1:0] w_win_bc_raw;
  logic [BURST_W-1:0] w_win_bc;
  logic               w_own_write;
  logic [BE_W-1:0]    w_own_be;
  logic [DATA_W-1:0]  w_own_wdata;
  logic               w_issue;
  logic               w_issue_wr;
  logic [ADDR_W-1:0]  w_ram_addr;
  logic [BE_W-1:0]    w_ram_be;
  logic [DATA_W-1:0]  w_ram_wdata;
  logic               w_wait0;
  logic               w_wait1;
  logic               w_cur_owner;
  logic               w_adv;

  // Nothing is granted during reset nor in the first cycle after it.
  assign w_blk     = i_reset | r_rst_dly;
  assign w_req0    = m0.read | m0.write;
  assign w_req1    = m1.read | m1.write;
  assign w_gnt_any = ~w_blk & (w_req0 | w_req1) & (r_state == ST_IDLE);
  // On a tie the port that did not win last time gets the RAM.
  assign w_gnt_id  = (w_req0 & w_req1) ? ~r_last_grant : w_req1;

  assign w_win_addr   = w_gnt_id ? m1.address    : m0.address;
  assign w_win_be     = w_gnt_id ? m1.byteenable : m0.byteenable;
  assign w_win_wdata  = w_gnt_id ? m1.writedata  : m0.writedata;
  assign w_win_write  = w_gnt_id ? m1.write      : m0.write;
  assign w_win_bc_raw = w_gnt_id ? m1.burstcount : m0.burstcount;
  assign w_win_bc     = (w_win_bc_raw == '0) ? BURST_W'(1) : w_win_bc_raw;

  assign w_own_write = r_owner ? m1.write      : m0.write;
  assign w_own_be    = r_owner ? m1.byteenable : m0.byteenable;
  assign w_own_wdata = r_owner ? m1.writedata  : m0.writedata;

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_issue_wr  = 1'b0;
    w_ram_addr  = r_addr;
    w_ram_be    = '1;
    w_ram_wdata = w_win_wdata;
    w_wait0     = 1'b1;
    w_wait1     = 1'b1;
    w_cur_owner = r_owner;
    w_adv       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_any) begin
          w_issue     = 1'b1;
          w_issue_wr  = w_win_write;
          w_ram_addr  = w_win_addr;
          w_ram_be    = w_win_write ? w_win_be : '1;
          w_ram_wdata = w_win_wdata;
          w_cur_owner = w_gnt_id;
          if (w_gnt_id) w_wait1 = 1'b0;
          else          w_wait0 = 1'b0;
          if (w_win_bc != BURST_W'(1)) begin
            w_state_nxt = w_win_write ? ST_WR_BURST : ST_RD_BURST;
          end
        end
      end
      ST_RD_BURST: begin
        if (!w_blk) begin
          w_issue = 1'b1;
          w_adv   = 1'b1;
          if (r_rem == BURST_W'(1)) w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_BURST: begin
        if (!w_blk) begin
          if (r_owner) w_wait1 = 1'b0;
          else         w_wait0 = 1'b0;
          // Owner may stall between beats; the lock is held until the last beat.
          if (w_own_write) begin
            w_issue     = 1'b1;
            w_issue_wr  = 1'b1;
            w_ram_be    = w_own_be;
            w_ram_wdata = w_own_wdata;
            w_adv       = 1'b1;
            if (r_rem == BURST_W'(1)) w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_rst_dly    <= 1'b1;
      r_addr       <= '0;
      r_rem        <= '0;
      r_rd_vld     <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_rst_dly  <= 1'b0;
      r_state    <= w_state_nxt;
      r_rd_vld   <= w_issue & ~w_issue_wr;
      r_rd_owner <= w_cur_owner;
      if (w_gnt_any) begin
        r_last_grant <= w_gnt_id;
        r_owner      <= w_gnt_id;
        r_addr       <= w_win_addr + 1'b1;
        r_rem        <= w_win_bc - 1'b1;
      end else if (w_adv) begin
        r_addr <= r_addr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end
    end
  end

  assign m0.waitrequest   = w_wait0;
  assign m1.waitrequest   = w_wait1;
  assign m0.readdata      = i_ram_readdata;
  assign m1.readdata      = i_ram_readdata;
  assign m0.readdatavalid = r_rd_vld & ~r_rd_owner & ~i_reset;
  assign m1.readdatavalid = r_rd_vld &  r_rd_owner & ~i_reset;

  assign o_ram_address    = w_ram_addr;
  assign o_ram_byteenable = w_ram_be;
  assign o_ram_chipselect = w_issue;
  assign o_ram_write      = w_issue_wr;
  assign o_ram_writedata  = w_ram_wdata;

`ifdef RAM_ARB_STATS_EN
  logic [31:0] r_stat_beats0;
  logic [31:0] r_stat_beats1;
  logic [31:0] r_stat_conflict;
  logic        w_conflict;

  assign w_conflict = (w_req0 & w_wait0) | (w_req1 & w_wait1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stat_beats0   <= '0;
      r_stat_beats1   <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_issue && !w_cur_owner && r_stat_beats0 != '1) r_stat_beats0 <= r_stat_beats0 + 32'd1;
      if (w_issue && w_cur_owner && r_stat_beats1 != '1)  r_stat_beats1 <= r_stat_beats1 + 32'd1;
      if (w_conflict && r_stat_conflict != '1) r_stat_conflict <= r_stat_conflict + 32'd1;
    end
  end

  assign o_stat_beats0   = r_stat_beats0;
  assign o_stat_beats1   = r_stat_beats1;
  assign o_stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_simple_system_onchip_ram_arbiter.sv
module tb_simple_system_onchip_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  simple_system_onchip_ram_arbiter_if m0_if ();
  simple_system_onchip_ram_arbiter_if m1_if ();

  logic [12:0] ram_address;
  logic [7:0]  ram_be;
  logic        ram_cs;
  logic        ram_we;
  logic [63:0] ram_wdata;
  logic [63:0] ram_q;
`ifdef RAM_ARB_STATS_EN
  logic [31:0] stat_b0, stat_b1, stat_cf;
`endif

  simple_system_onchip_ram_arbiter dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .m0               (m0_if.slave),
    .m1               (m1_if.slave),
    .o_ram_address    (ram_address),
    .o_ram_byteenable (ram_be),
    .o_ram_chipselect (ram_cs),
    .o_ram_write      (ram_we),
    .o_ram_writedata  (ram_wdata),
`ifdef RAM_ARB_STATS_EN
    .o_stat_beats0    (stat_b0),
    .o_stat_beats1    (stat_b1),
    .o_stat_conflict  (stat_cf),
`endif
    .i_ram_readdata   (ram_q)
  );

  // Behavioural single-port RAM, 1-cycle synchronous read.
  logic [63:0] ram_mem [8192];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) begin
        for (int b = 0; b < 8; b++) if (ram_be[b]) ram_mem[ram_address][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end else begin
        ram_q <= ram_mem[ram_address];
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit port; logic [63:0] data; int cyc; } exp_t;
  exp_t sb_q[$];
  typedef struct { logic [12:0] addr; bit we; logic [63:0] wdata; } log_t;
  log_t log_q[$];
  logic [63:0] exp_mem [8192];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // RAM access log and read-return scoreboard.
  always @(negedge clk) begin
    if (!rst && ram_cs) log_q.push_back('{ram_address, ram_we, ram_wdata});
  end

  always @(negedge clk) begin
    exp_t e;
    if (m0_if.readdatavalid || m1_if.readdatavalid) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdv_unexpected: got valid m0=%0b m1=%0b, required none",
                 m0_if.readdatavalid, m1_if.readdatavalid);
      end else begin
        e = sb_q.pop_front();
        chk("rdv_port", {62'd0, m1_if.readdatavalid, m0_if.readdatavalid}, e.port ? 64'd2 : 64'd1);
        chk("rdata", e.port ? m1_if.readdata : m0_if.readdata, e.data);
        chk("rd_latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic drv(input int p, input bit rd, input bit wr, input logic [12:0] a,
                     input logic [7:0] be, input logic [63:0] d, input logic [3:0] bc);
    if (p == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
      m0_if.byteenable = be; m0_if.writedata = d; m0_if.burstcount = bc;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
      m1_if.byteenable = be; m1_if.writedata = d; m1_if.burstcount = bc;
    end
  endtask

  task automatic idle(input int p);
    drv(p, 1'b0, 1'b0, 13'h0, 8'hFF, 64'h0, 4'd1);
  endtask

  function automatic logic wreq(input int p);
    return (p == 0) ? m0_if.waitrequest : m1_if.waitrequest;
  endfunction

  task automatic mem_upd(input logic [12:0] a, input logic [7:0] be, input logic [63:0] d);
    for (int b = 0; b < 8; b++) if (be[b]) exp_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic wait_grant(input int p, output int g);
    g = -1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (wreq(p) == 1'b0) begin
        g = cyc;
        break;
      end
    end
    if (g < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: port %0d got no grant, required grant within 32 cycles", p);
    end
  endtask

  task automatic single(input int p, input bit wr, input logic [12:0] a, input logic [7:0] be,
                        input logic [63:0] d, input logic [63:0] e);
    int g;
    @(posedge clk); #1;
    drv(p, !wr, wr, a, be, d, 4'd1);
    wait_grant(p, g);
    if (g >= 0) begin
      if (wr) mem_upd(a, be, d);
      else sb_q.push_back('{bit'(p), e, g + 1});
    end
    @(posedge clk); #1;
    idle(p);
  endtask

  // Leaves the caller at posedge+1 of the cycle after the grant.
  task automatic burst_read(input int p, input logic [12:0] a, input int n);
    int g;
    logic [12:0] a2;
    @(posedge clk); #1;
    drv(p, 1'b1, 1'b0, a, 8'hFF, 64'h0, 4'(n));
    wait_grant(p, g);
    if (g >= 0) begin
      for (int i = 0; i < n; i++) begin
        a2 = a + 13'(i);
        sb_q.push_back('{bit'(p), exp_mem[a2], g + 1 + i});
      end
    end
    @(posedge clk); #1;
    idle(p);
  endtask

  task automatic chk_log(input int idx, input logic [12:0] a, input bit we, input logic [63:0] d);
    if (idx < log_q.size()) begin
      chk("log_addr", 64'(log_q[idx].addr), 64'(a));
      chk("log_we", 64'(log_q[idx].we), 64'(we));
      if (we) chk("log_wdata", log_q[idx].wdata, d);
    end else begin
      checks++;
      errors++;
      $display("FAIL log_missing: got %0d RAM accesses, required entry %0d", log_q.size(), idx);
    end
  endtask

  typedef struct {
    int          port;
    bit          wr;
    logic [12:0] addr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs[14];

  localparam logic [63:0] DA = 64'hDEADBEEF00C0FFEE;
  localparam logic [63:0] DB = 64'h0BADF00D12345678;
  localparam logic [63:0] D0 = 64'hA0A0A0A0A0A0A0A0;
  localparam logic [63:0] D1 = 64'hB1B1B1B1B1B1B1B1;
  localparam logic [63:0] D2 = 64'hC2C2C2C2C2C2C2C2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    vecs[0]  = '{0, 1'b1, 13'h010,  8'hFF, 64'h0123456789ABCDEF, 64'h0};
    vecs[1]  = '{0, 1'b0, 13'h010,  8'hFF, 64'h0, 64'h0123456789ABCDEF};
    vecs[2]  = '{1, 1'b1, 13'h020,  8'hFF, 64'hFFFFFFFFFFFFFFFF, 64'h0};
    vecs[3]  = '{1, 1'b1, 13'h020,  8'h0F, 64'h0, 64'h0};
    vecs[4]  = '{0, 1'b0, 13'h020,  8'hFF, 64'h0, 64'hFFFFFFFF00000000};
    vecs[5]  = '{1, 1'b0, 13'h010,  8'hFF, 64'h0, 64'h0123456789ABCDEF};
    vecs[6]  = '{1, 1'b1, 13'h1FFE, 8'hFF, 64'h1111111111111111, 64'h0};
    vecs[7]  = '{0, 1'b1, 13'h1FFF, 8'hFF, 64'h2222222222222222, 64'h0};
    vecs[8]  = '{1, 1'b1, 13'h0000, 8'hFF, 64'h3333333333333333, 64'h0};
    vecs[9]  = '{0, 1'b1, 13'h0001, 8'hFF, 64'h4444444444444444, 64'h0};
    vecs[10] = '{0, 1'b1, 13'h0000, 8'hF0, 64'h5555666677778888, 64'h0};
    vecs[11] = '{1, 1'b0, 13'h0000, 8'hFF, 64'h0, 64'h5555666633333333};
    vecs[12] = '{0, 1'b0, 13'h040,  8'hFF, 64'h0, DA};
    vecs[13] = '{1, 1'b0, 13'h1FFF, 8'hFF, 64'h0, 64'h2222222222222222};

    // Reset: a pending request must not be granted during reset or the cycle after.
    rst = 1'b1;
    idle(0);
    idle(1);
    drv(0, 1'b1, 1'b0, 13'h010, 8'hFF, 64'h0, 4'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wait0", 64'(m0_if.waitrequest), 64'd1);
    chk("rst_wait1", 64'(m1_if.waitrequest), 64'd1);
    chk("rst_rdv0", 64'(m0_if.readdatavalid), 64'd0);
    chk("rst_rdv1", 64'(m1_if.readdatavalid), 64'd0);
    chk("rst_cs", 64'(ram_cs), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wait0", 64'(m0_if.waitrequest), 64'd1);
    chk("post_rst_cs", 64'(ram_cs), 64'd0);
    @(posedge clk); #1;
    idle(0);

    // Tie straight after reset: m0 first, m1 the next cycle.
    log_q.delete();
    @(posedge clk); #1;
    drv(0, 1'b0, 1'b1, 13'h040, 8'hFF, DA, 4'd1);
    drv(1, 1'b0, 1'b1, 13'h041, 8'hFF, DB, 4'd1);
    @(negedge clk);
    chk("rr0_m0_wait", 64'(m0_if.waitrequest), 64'd0);
    chk("rr0_m1_wait", 64'(m1_if.waitrequest), 64'd1);
    mem_upd(13'h040, 8'hFF, DA);
    @(posedge clk); #1;
    idle(0);
    @(negedge clk);
    chk("rr1_m1_wait", 64'(m1_if.waitrequest), 64'd0);
    mem_upd(13'h041, 8'hFF, DB);
    @(posedge clk); #1;
    idle(1);
    repeat (2) @(negedge clk);
    chk("rr_log_n", 64'(log_q.size()), 64'd2);
    chk_log(0, 13'h040, 1'b1, DA);
    chk_log(1, 13'h041, 1'b1, DB);

    // Table of single-beat transactions.
    for (int i = 0; i < 14; i++) begin
      single(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp);
    end

    // m0 alone leaves last_grant=0, so the next tie goes to m1.
    single(0, 1'b0, 13'h041, 8'hFF, 64'h0, DB);
    @(posedge clk); #1;
    drv(0, 1'b1, 1'b0, 13'h010, 8'hFF, 64'h0, 4'd1);
    drv(1, 1'b1, 1'b0, 13'h040, 8'hFF, 64'h0, 4'd1);
    @(negedge clk);
    chk("rr2_m1_wait", 64'(m1_if.waitrequest), 64'd0);
    chk("rr2_m0_wait", 64'(m0_if.waitrequest), 64'd1);
    sb_q.push_back('{1'b1, DA, cyc + 1});
    @(posedge clk); #1;
    idle(1);
    @(negedge clk);
    chk("rr3_m0_wait", 64'(m0_if.waitrequest), 64'd0);
    sb_q.push_back('{1'b0, 64'h0123456789ABCDEF, cyc + 1});
    @(posedge clk); #1;
    idle(0);

    // m1 read burst of 4 across the top of the address space; m0 locked out.
    repeat (2) @(posedge clk);
    log_q.delete();
    burst_read(1, 13'h1FFE, 4);
    drv(0, 1'b1, 1'b0, 13'h010, 8'hFF, 64'h0, 4'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rdb_m0_blocked", 64'(m0_if.waitrequest), 64'd1);
      chk("rdb_m1_wait", 64'(m1_if.waitrequest), 64'd1);
    end
    @(negedge clk);
    chk("rdb_m0_after", 64'(m0_if.waitrequest), 64'd0);
    sb_q.push_back('{1'b0, 64'h0123456789ABCDEF, cyc + 1});
    @(posedge clk); #1;
    idle(0);
    repeat (3) @(negedge clk);
    chk("rdb_log_n", 64'(log_q.size()), 64'd5);
    chk_log(0, 13'h1FFE, 1'b0, 64'h0);
    chk_log(1, 13'h1FFF, 1'b0, 64'h0);
    chk_log(2, 13'h0000, 1'b0, 64'h0);
    chk_log(3, 13'h0001, 1'b0, 64'h0);
    chk_log(4, 13'h0010, 1'b0, 64'h0);

    // m0 write burst of 3 with a 2-cycle stall after beat 1; m1 waits for the last beat.
    @(posedge clk); #1;
    log_q.delete();
    drv(0, 1'b0, 1'b1, 13'h100, 8'hFF, D0, 4'd3);
    wait_grant(0, g);
    mem_upd(13'h100, 8'hFF, D0);
    @(posedge clk); #1;
    m0_if.write = 1'b0;
    drv(1, 1'b1, 1'b0, 13'h040, 8'hFF, 64'h0, 4'd1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("wrb_stall_m0_wait", 64'(m0_if.waitrequest), 64'd0);
      chk("wrb_stall_m1_wait", 64'(m1_if.waitrequest), 64'd1);
      chk("wrb_stall_cs", 64'(ram_cs), 64'd0);
      @(posedge clk); #1;
    end
    m0_if.write = 1'b1;
    m0_if.writedata = D1;
    @(negedge clk);
    chk("wrb_b2_m1_wait", 64'(m1_if.waitrequest), 64'd1);
    @(posedge clk); #1;
    m0_if.writedata = D2;
    @(negedge clk);
    chk("wrb_b3_m1_wait", 64'(m1_if.waitrequest), 64'd1);
    mem_upd(13'h101, 8'hFF, D1);
    mem_upd(13'h102, 8'hFF, D2);
    @(posedge clk); #1;
    idle(0);
    @(negedge clk);
    chk("wrb_m1_after", 64'(m1_if.waitrequest), 64'd0);
    sb_q.push_back('{1'b1, DA, cyc + 1});
    @(posedge clk); #1;
    idle(1);
    repeat (2) @(negedge clk);
    chk("wrb_log_n", 64'(log_q.size()), 64'd4);
    chk_log(0, 13'h100, 1'b1, D0);
    chk_log(1, 13'h101, 1'b1, D1);
    chk_log(2, 13'h102, 1'b1, D2);
    chk_log(3, 13'h040, 1'b0, 64'h0);
    burst_read(0, 13'h100, 3);
    repeat (4) @(posedge clk);

    // Reset during beat 2 of a read burst of 8.
    #1;
    log_q.delete();
    drv(0, 1'b1, 1'b0, 13'h100, 8'hFF, 64'h0, 4'd8);
    wait_grant(0, g);
    @(posedge clk); #1;
    rst = 1'b1;
    idle(0);
    @(negedge clk);
    chk("mid_rst_cs", 64'(ram_cs), 64'd0);
    chk("mid_rst_rdv0", 64'(m0_if.readdatavalid), 64'd0);
    chk("mid_rst_wait0", 64'(m0_if.waitrequest), 64'd1);
    chk("mid_rst_wait1", 64'(m1_if.waitrequest), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_post_rdv0", 64'(m0_if.readdatavalid), 64'd0);
    chk("mid_rst_post_cs", 64'(ram_cs), 64'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_log_n", 64'(log_q.size()), 64'd1);
    chk("mid_rst_sb_empty", 64'(sb_q.size()), 64'd0);
    single(1, 1'b0, 13'h010, 8'hFF, 64'h0, 64'h0123456789ABCDEF);
    single(0, 1'b0, 13'h102, 8'hFF, 64'h0, D2);

    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
